// File: rtl/prim_packer_fifo.sv
// prim_packer_fifo: packs variable-width masked input beats into OutW-bit words queued in a Depth-entry FIFO
//   clk_i, rst_i (async, active-high)
//   valid_i/data_i/mask_i/ready_o : input beats; set mask bits must be contiguous
//   valid_o/data_o/mask_o/ready_i : FIFO head; mask is all-ones except a flushed partial word
//   flush_i/flush_done_o           : emit the remnant as a partial word, pulse when drained
//   err_o                          : one-cycle pulse after an illegal mask was consumed
//   fifo_depth_o                   : FIFO occupancy
module prim_packer_fifo #(
    parameter int InW          = 32,
    parameter int OutW         = 64,
    parameter int Depth        = 2,
    parameter int HintByteData = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [InW-1:0]             data_i,
    input  logic [InW-1:0]             mask_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic [OutW-1:0]            data_o,
    output logic [OutW-1:0]            mask_o,
    input  logic                       ready_i,
    input  logic                       flush_i,
    output logic                       flush_done_o,
    output logic                       err_o,
    output logic [$clog2(Depth+1)-1:0] fifo_depth_o
);
    localparam int AccW = InW + OutW;
    localparam int PW   = $clog2(AccW + 1);
    localparam int DW   = $clog2(Depth + 1);
    localparam int AW   = Depth > 1 ? $clog2(Depth) : 1;
    localparam logic [OutW-1:0] Ones = '1;

    typedef enum logic [1:0] {Idle, Drain, Done} state_e;

    state_e          state_q, state_d;
    logic [AccW-1:0] acc_q, acc_d, acc_app;
    logic [PW-1:0]   pos_q, pos_d, pos_app, ones;
    logic            err_q;
    logic [OutW-1:0] mem_data_q [Depth];
    logic [OutW-1:0] mem_mask_q [Depth];
    logic [AW-1:0]   wr_q, rd_q;
    logic [DW-1:0]   cnt_q;
    logic [InW-1:0]  mask_sh, data_sh;
    logic            legal, accept, app, pop, room, push_full, push_part, push;
    logic [OutW-1:0] push_mask;

    // Normalise the beat so its lowest set mask bit lands at bit 0; contiguity then
    // means the shifted mask has the form 2^k-1.
    always_comb begin
        mask_sh = mask_i;
        data_sh = data_i;
        ones    = '0;
        for (int i = 0; i < InW; i++) ones = ones + PW'(mask_i[i]);
        for (int i = InW - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                mask_sh = mask_i >> i;
                data_sh = data_i >> i;
            end
        end
        legal = (mask_sh & (mask_sh + InW'(1))) == '0;
        if (HintByteData != 0) begin
            for (int b = 0; b < InW / 8; b++) begin
                if (mask_i[8*b+:8] != 8'h00 && mask_i[8*b+:8] != 8'hFF) legal = 1'b0;
            end
        end
    end

    assign ready_o      = (pos_q <= PW'(OutW)) && (state_q == Idle);
    assign valid_o      = cnt_q != '0;
    assign data_o       = mem_data_q[rd_q];
    assign mask_o       = mem_mask_q[rd_q];
    assign flush_done_o = state_q == Done;
    assign err_o        = err_q;
    assign fifo_depth_o = cnt_q;

    always_comb begin
        accept    = valid_i & ready_o;
        app       = accept & legal;
        pos_app   = pos_q + (app ? ones : '0);
        acc_app   = acc_q | (app ? (AccW'(data_sh & mask_sh) << pos_q) : '0);
        pop       = valid_o & ready_i;
        room      = (cnt_q != DW'(Depth)) | pop;
        push_full = room && (pos_app >= PW'(OutW));
        // A partial word only leaves while draining, and only once no full word remains.
        push_part = room && (state_q == Drain) && (pos_app != '0) && (pos_app < PW'(OutW));
        push      = push_full | push_part;
        push_mask = push_full ? Ones : ~(Ones << pos_app);
        acc_d     = push_full ? (acc_app >> OutW) : (push_part ? '0 : acc_app);
        pos_d     = push_full ? (pos_app - PW'(OutW)) : (push_part ? '0 : pos_app);
        state_d   = state_q;
        case (state_q)
            Idle:    state_d = flush_i ? Drain : Idle;
            Drain:   state_d = (pos_q == '0 && cnt_q == '0) ? Done : Drain;
            default: state_d = Idle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            acc_q   <= '0;
            pos_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_data_q[i] <= '0;
                mem_mask_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pos_q   <= pos_d;
            err_q   <= accept && (mask_i != '0) && !legal;
            cnt_q   <= cnt_q + DW'(push) - DW'(pop);
            if (push) begin
                mem_data_q[wr_q] <= acc_app[OutW-1:0];
                mem_mask_q[wr_q] <= push_mask;
                wr_q             <= (wr_q == AW'(Depth - 1)) ? '0 : wr_q + AW'(1);
            end
            if (pop) rd_q <= (rd_q == AW'(Depth - 1)) ? '0 : rd_q + AW'(1);
        end
    end
endmodule

// File: tb/tb_prim_packer_fifo.sv
// tb_prim_packer_fifo: vector table, corner sequences and randomized scoreboard for prim_packer_fifo
module tb_prim_packer_fifo;
    logic        clk = 1'b0, rst;
    logic        valid_i, ready_i, flush_i;
    logic [31:0] data_i, mask_i;
    logic        a_ready, a_valid, a_fd, a_err, b_ready, b_valid, b_fd, b_err;
    logic [63:0] a_data, a_mask, b_data, b_mask;
    logic [1:0]  a_depth, b_depth;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    prim_packer_fifo #(.InW(32), .OutW(64), .Depth(2), .HintByteData(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i), .mask_i(mask_i),
        .ready_o(a_ready), .valid_o(a_valid), .data_o(a_data), .mask_o(a_mask),
        .ready_i(ready_i), .flush_i(flush_i), .flush_done_o(a_fd), .err_o(a_err),
        .fifo_depth_o(a_depth));

    prim_packer_fifo #(.InW(32), .OutW(64), .Depth(2), .HintByteData(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i), .mask_i(mask_i),
        .ready_o(b_ready), .valid_o(b_valid), .data_o(b_data), .mask_o(b_mask),
        .ready_i(ready_i), .flush_i(flush_i), .flush_done_o(b_fd), .err_o(b_err),
        .fifo_depth_o(b_depth));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit bq[$];
    logic [63:0] exp_d[$], exp_m[$];
    logic exp_err = 1'b0;

    typedef struct packed {
        logic v; logic [31:0] d; logic [31:0] m; logic ri;
        logic ev; logic [63:0] ed; logic rdy; logic err; logic [1:0] dep;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // A mask is legal when it equals a run of popcount ones starting at its lowest set bit.
    function automatic bit legal_m(input logic [31:0] m);
        int c = $countones(m);
        int lo = 0;
        logic [63:0] e;
        if (c == 0) return 1'b1;
        while (!m[lo]) lo++;
        e = ((64'd1 << c) - 64'd1) << lo;
        return {32'h0, m} == e;
    endfunction

    task automatic model_clear();
        bq.delete(); exp_d.delete(); exp_m.delete(); exp_err = 1'b0;
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [31:0] m);
        int lo = 0;
        logic [63:0] w;
        while (!m[lo]) lo++;
        for (int k = 0; k < $countones(m); k++) bq.push_back(d[lo+k]);
        while (bq.size() >= 64) begin
            for (int k = 0; k < 64; k++) w[k] = bq.pop_front();
            exp_d.push_back(w); exp_m.push_back(ONES);
        end
    endtask

    task automatic model_flush();
        logic [63:0] w = '0, mk = '0;
        int n = bq.size();
        if (n == 0) return;
        for (int k = 0; k < n; k++) begin w[k] = bq.pop_front(); mk[k] = 1'b1; end
        exp_d.push_back(w); exp_m.push_back(mk);
    endtask

    task automatic cyc();
        logic acc = valid_i & a_ready, pop = a_valid & ready_i, fl = flush_i;
        logic [31:0] d = data_i, m = mask_i;
        if (pop) begin
            if (exp_d.size() == 0) begin
                n_chk++;
                $display("FAIL sb_word: got unexpected word %h, expected none", a_data);
            end else begin
                chk("sb_data", a_data, exp_d.pop_front());
                chk("sb_mask", a_mask, exp_m.pop_front());
            end
        end
        @(posedge clk); #1;
        exp_err = 1'b0;
        if (acc && m != 0) begin
            if (legal_m(m)) model_beat(d, m);
            else exp_err = 1'b1;
        end
        if (fl) model_flush();
        chk("err", {63'h0, a_err}, {63'h0, exp_err});
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 0; flush_i = 0; ready_i = 0; data_i = 0; mask_i = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic beat(input logic [31:0] d, input logic [31:0] m);
        valid_i = 1'b1; data_i = d; mask_i = m; cyc(); valid_i = 1'b0;
    endtask

    vec_t tbl[20];
    logic [63:0] got[$];
    int pulses;
    logic bad, seen;

    initial begin
        tbl[0]  = '{1'b1, 32'h11111111, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 32'h22222222, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h2222222211111111, 1'b1, 1'b0, 2'd1};
        tbl[2]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 32'h0000AAAA, 32'h0000FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[4]  = '{1'b1, 32'h0000BBBB, 32'h0000FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[5]  = '{1'b1, 32'h0000CCCC, 32'h0000FFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[6]  = '{1'b1, 32'h0000DDDD, 32'h0000FFFF, 1'b0, 1'b1, 64'hDDDDCCCCBBBBAAAA, 1'b1, 1'b0, 2'd1};
        tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[8]  = '{1'b1, 32'hEEEE0000, 32'hFFFF0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[9]  = '{1'b1, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[10] = '{1'b1, 32'h00009999, 32'h0000FFFF, 1'b0, 1'b1, 64'h999912345678EEEE, 1'b1, 1'b0, 2'd1};
        tbl[11] = '{1'b1, 32'hDEADBEEF, 32'h00FF00FF, 1'b1, 1'b0, 64'h0, 1'b1, 1'b1, 2'd0};
        tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[13] = '{1'b1, 32'h01020304, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[14] = '{1'b1, 32'h05060708, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h0506070801020304, 1'b1, 1'b0, 2'd1};
        tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[17] = '{1'b1, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};
        tbl[18] = '{1'b1, 32'h0BADC0DE, 32'hFFFFFFFF, 1'b0, 1'b1, 64'h0BADC0DECAFEF00D, 1'b1, 1'b0, 2'd1};
        tbl[19] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 2'd0};

        do_reset();
        chk("rst_valid", {63'h0, a_valid}, 64'h0);
        chk("rst_data", a_data, 64'h0);
        chk("rst_mask", a_mask, 64'h0);
        chk("rst_ready", {63'h0, a_ready}, 64'h1);
        chk("rst_fd", {63'h0, a_fd}, 64'h0);
        chk("rst_depth", {62'h0, a_depth}, 64'h0);

        foreach (tbl[i]) begin
            valid_i = tbl[i].v; data_i = tbl[i].d; mask_i = tbl[i].m; ready_i = tbl[i].ri;
            cyc();
            chk($sformatf("vec%0d_valid", i), {63'h0, a_valid}, {63'h0, tbl[i].ev});
            chk($sformatf("vec%0d_ready", i), {63'h0, a_ready}, {63'h0, tbl[i].rdy});
            chk($sformatf("vec%0d_err", i), {63'h0, a_err}, {63'h0, tbl[i].err});
            chk($sformatf("vec%0d_depth", i), {62'h0, a_depth}, {62'h0, tbl[i].dep});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), a_data, tbl[i].ed);
                chk($sformatf("vec%0d_mask", i), a_mask, ONES);
            end
        end
        valid_i = 0; ready_i = 0;

        // byte-granularity checking only in the HintByteData instance
        do_reset();
        beat(32'h5, 32'h0000000F);
        chk("hint_err_a", {63'h0, a_err}, 64'h0);
        chk("hint_err_b", {63'h0, b_err}, 64'h1);
        beat(32'h1200, 32'h0000FF00);
        chk("hint_ok_b", {63'h0, b_err}, 64'h0);

        // backpressure: two full FIFO entries, a full accumulator, then a drain
        do_reset();
        for (int i = 1; i <= 6; i++) beat(32'h10000000 + i, 32'hFFFFFFFF);
        chk("bp_depth", {62'h0, a_depth}, 64'h2);
        chk("bp_ready64", {63'h0, a_ready}, 64'h1);
        beat(32'h10000007, 32'hFFFFFFFF);
        chk("bp_ready96", {63'h0, a_ready}, 64'h0);
        ready_i = 1'b1;
        got.delete();
        for (int i = 0; i < 12 && got.size() < 3; i++) begin
            if (a_valid) got.push_back(a_data);
            cyc();
        end
        chk("bp_nwords", 64'(got.size()), 64'd3);
        for (int i = 0; i < got.size() && i < 3; i++)
            chk($sformatf("bp_word%0d", i), got[i], {32'h10000002 + 2 * i, 32'h10000001 + 2 * i});
        chk("bp_ready_back", {63'h0, a_ready}, 64'h1);
        chk("bp_depth0", {62'h0, a_depth}, 64'h0);

        // partial flush
        do_reset();
        beat(32'h00CCBBAA, 32'h00FFFFFF);
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        chk("fl_ready_drain", {63'h0, a_ready}, 64'h0);
        cyc();
        chk("fl_valid", {63'h0, a_valid}, 64'h1);
        chk("fl_data", a_data, 64'h0000000000CCBBAA);
        chk("fl_mask", a_mask, 64'h0000000000FFFFFF);
        chk("fl_ready_word", {63'h0, a_ready}, 64'h0);
        ready_i = 1'b1; pulses = 0; bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (a_fd) pulses++;
            if (pulses == 0 && a_ready) bad = 1'b1;
        end
        chk("fl_pulses", 64'(pulses), 64'd1);
        chk("fl_ready_low", {63'h0, bad}, 64'h0);
        chk("fl_ready_idle", {63'h0, a_ready}, 64'h1);

        // empty flush completes two cycles after the request
        ready_i = 1'b0;
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        chk("fle_fd1", {63'h0, a_fd}, 64'h0);
        cyc();
        chk("fle_fd2", {63'h0, a_fd}, 64'h1);
        cyc();
        chk("fle_fd3", {63'h0, a_fd}, 64'h0);

        // asynchronous reset while draining with one queued word
        do_reset();
        beat(32'h0000AAAA, 32'hFFFFFFFF);
        beat(32'h0000BBBB, 32'hFFFFFFFF);
        chk("rd_depth1", {62'h0, a_depth}, 64'h1);
        flush_i = 1'b1; cyc(); flush_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rd_valid", {63'h0, a_valid}, 64'h0);
        chk("rd_depth", {62'h0, a_depth}, 64'h0);
        chk("rd_ready", {63'h0, a_ready}, 64'h1);
        @(negedge clk) rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rd_no_fd", {63'h0, a_fd}, 64'h0);
        end

        // randomized traffic against the bit-stream model, with periodic flushes
        do_reset();
        for (int blk = 0; blk < 9; blk++) begin
            for (int c = 0; c < 300; c++) begin
                valid_i = $urandom_range(0, 9) < 7;
                data_i  = $urandom;
                ready_i = $urandom_range(0, 9) < 6;
                case ($urandom_range(0, 3))
                    0: mask_i = 32'hFFFFFFFF;
                    1: begin
                        int lo = $urandom_range(0, 31);
                        logic [63:0] r = ((64'd1 << $urandom_range(1, 32 - lo)) - 64'd1) << lo;
                        mask_i = r[31:0];
                    end
                    2: mask_i = 32'h0;
                    default: mask_i = $urandom;
                endcase
                cyc();
            end
            valid_i = 1'b0;
            if (blk == 8) ready_i = 1'b1;
            flush_i = 1'b1; cyc(); flush_i = 1'b0;
            seen = 1'b0;
            for (int c = 0; c < 300 && !seen; c++) begin
                if (blk != 8) ready_i = $urandom_range(0, 1);
                cyc();
                seen = a_fd;
            end
            chk("rand_flush_done", {63'h0, seen}, 64'h1);
        end
        chk("rand_sb_empty", 64'(exp_d.size()), 64'd0);
        chk("rand_fifo_empty", {62'h0, a_depth}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prim_packer_fifo.md
Name: prim_packer_fifo

Overview:
Parametrised successor packer. It compacts variable-width masked input beats into full OutW-bit output words and queues completed words in a Depth-entry output FIFO. It adds mask-legality checking (contiguity, byte granularity), flush with partial-word emission, and FIFO occupancy reporting. It sits between narrow/sparse producers (e.g. a message/key feed) and a wide fixed-width consumer.

Parameters:
InW, 32, input data/mask width.
OutW, 64, output data/mask width. Must be >= InW.
Depth, 2, output FIFO entries. Must be >= 1.
HintByteData, 0, if 1 the mask must be byte-uniform (each 8-bit mask group all-0 or all-1); InW and OutW must be multiples of 8.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
valid_i  in  1  input beat valid
data_i  in  InW  input data
mask_i  in  InW  input mask; set bits must be contiguous
ready_o  out  1  input accept
valid_o  out  1  output word valid (FIFO non-empty)
data_o  out  OutW  FIFO head data
mask_o  out  OutW  FIFO head mask; all-ones except the final flushed word
ready_i  in  1  consumer accept
flush_i  in  1  request emission of remnant
flush_done_o  out  1  one-cycle pulse when flush is complete
err_o  out  1  one-cycle pulse: illegal mask seen
fifo_depth_o  out  $clog2(Depth+1)  FIFO occupancy

Behaviour:
- Reset (async, rst_i=1): accumulator, pos, FIFO and flush FSM cleared. Outputs: valid_o=0, data_o=0, mask_o=0, ready_o=1, flush_done_o=0, err_o=0, fifo_depth_o=0. Reset mid-flush or mid-packing discards all state.
- Storage: accumulator of InW+OutW bits plus pos counter, $clog2(InW+OutW+1) bits wide.
- ready_o = (pos <= OutW) && flush FSM in Idle. It depends on registered state only; there is no valid_i->ready_o path.
- Accept = valid_i & ready_o. On accept:
  - The mask is legal if its set bits are contiguous. With HintByteData=1 it must also be byte-uniform.
  - Legal: data bits from the lowest set mask bit upward are appended at bit pos; pos += popcount(mask_i).
  - Illegal: the beat is consumed and discarded, pos is unchanged, and err_o pulses on the next cycle.
  - All-zero mask: accepted, no effect, no error.
- Push: in any cycle where the effective pos (after the same-cycle append) is >= OutW and the FIFO is not full, or is full with a simultaneous pop:
  - The low OutW bits are written to the FIFO with mask all-ones.
  - The accumulator shifts right by OutW and pos -= OutW.
  - At most one push per cycle.
- Latency: a beat that completes a word at edge N gives valid_o=1 after edge N (word visible in cycle N+1), provided the FIFO has room.
- FIFO full: pos may remain >= OutW. ready_o deasserts when pos > OutW, so the accumulator never overflows.
- Pop: valid_o & ready_i. Push and pop in the same cycle is allowed at full and at empty. Output is head-of-queue, registered storage, in order.
- Flush FSM:
  - Idle: flush_i=1 moves to Drain. flush_i while already in Drain is ignored.
  - Drain: ready_o=0. Full words push normally. When 0 < pos < OutW and the FIFO is not full, one partial word is pushed: data = accumulator low bits, mask = (1<<pos)-1. pos then goes to 0.
  - Drain moves to Done once pos==0 and the FIFO is empty.
  - Done: flush_done_o=1 for one cycle, then Idle.
  - Flush with pos=0 and an empty FIFO: flush_done_o pulses 2 cycles after flush_i.
- fifo_depth_o is the registered count, ranging 0..Depth.

Test Plan (InW=32, OutW=64, Depth=2):
1. Full beats: accept 0x11111111 then 0x22222222, mask 0xFFFFFFFF -> next cycle valid_o=1, data_o=0x2222222211111111, mask_o all-ones, fifo_depth_o=1.
2. Half beats: data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD, mask 0x0000FFFF each -> data_o=0xDDDDCCCCBBBBAAAA. Then shifted mask 0xFFFF0000 with data 0xEEEE0000 is compacted as 0xEEEE at pos 0.
3. Illegal mask 0x00FF00FF with valid_i -> beat accepted, err_o pulses one cycle, pos unchanged, no output word. Repeat with HintByteData=1 and mask 0x0000000F -> err_o pulses.
4. Backpressure: ready_i=0, stream full beats -> FIFO reaches 2 and pos reaches 64, then ready_o=0. Set ready_i=1 -> three words drain in input order and ready_o reasserts.
5. Partial flush: accept data 0x00CCBBAA, mask 0x00FFFFFF, then pulse flush_i -> output word data 0x0000000000CCBBAA, mask 0x0000000000FFFFFF, ready_o=0 throughout. After the pop, flush_done_o pulses once.
6. Reset during Drain with FIFO occupancy 1 -> immediately valid_o=0, fifo_depth_o=0, ready_o=1, no flush_done_o pulse after release.
